// File: rtl/tmds_rx_align_decode.sv
// TMDS receive channel: finds the symbol boundary from control-token runs and decodes symbols.
// Optional statistics ports are enabled with the SMOLDVI_TMDS_RX_STATS_EN macro.
module tmds_rx_align_decode #(
   parameter int unsigned LOCK_COUNT     = 8,
   parameter int unsigned SEARCH_TIMEOUT = 2048
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [9:0]  d,
   output logic        q_valid,
   output logic        q_de,
   output logic [7:0]  q_data,
   output logic [1:0]  q_c,
   output logic        locked,
   output logic [3:0]  slip_offset
`ifdef SMOLDVI_TMDS_RX_STATS_EN
   ,
   output logic [15:0] stat_lines,
   output logic [7:0]  stat_slips
`endif
);

   localparam int unsigned RunW  = $clog2(LOCK_COUNT + 1);
   localparam int unsigned IdleW = (SEARCH_TIMEOUT > 1) ? $clog2(SEARCH_TIMEOUT) : 1;

   localparam logic [9:0] TokC0 = 10'b1101010100;
   localparam logic [9:0] TokC1 = 10'b0010101011;
   localparam logic [9:0] TokC2 = 10'b0101010100;
   localparam logic [9:0] TokC3 = 10'b1010101011;

   typedef enum logic [0:0] {StSearch, StLocked} state_e;

   state_e           state_q;
   logic [9:0]       d_prev_q;
   logic [9:0]       sym_q;
   logic [RunW-1:0]  run_q;
   logic [IdleW-1:0] idle_q;

   logic [19:0]      win;
   logic             is_ctrl;
   logic [1:0]       ctrl_code;
   logic [7:0]       s_lo;
   logic [7:0]       data_dec;
   logic             lock_hit;
   logic             idle_end;
   logic             slip_evt;
   logic             drop_evt;

   assign win = {d, d_prev_q};

   always_comb begin
      is_ctrl   = 1'b1;
      ctrl_code = 2'b00;
      case (sym_q)
         TokC0:   ctrl_code = 2'b00;
         TokC1:   ctrl_code = 2'b01;
         TokC2:   ctrl_code = 2'b10;
         TokC3:   ctrl_code = 2'b11;
         default: is_ctrl = 1'b0;
      endcase

      // Undo the optional inversion, then the XOR/XNOR transition chain.
      s_lo        = sym_q[9] ? ~sym_q[7:0] : sym_q[7:0];
      data_dec    = 8'h00;
      data_dec[0] = s_lo[0];
      for (int i = 1; i < 8; i++) begin
         data_dec[i] = sym_q[8] ? (s_lo[i] ^ s_lo[i-1]) : ~(s_lo[i] ^ s_lo[i-1]);
      end

      lock_hit = (state_q == StSearch) && is_ctrl && (run_q == RunW'(LOCK_COUNT - 1));
      idle_end = (idle_q == IdleW'(SEARCH_TIMEOUT - 1));
      slip_evt = (state_q == StSearch) && !lock_hit && idle_end;
      drop_evt = (state_q == StLocked) && !is_ctrl && idle_end;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StSearch;
         d_prev_q    <= 10'd0;
         sym_q       <= 10'd0;
         run_q       <= '0;
         idle_q      <= '0;
         slip_offset <= 4'd0;
         locked      <= 1'b0;
         q_valid     <= 1'b0;
         q_de        <= 1'b0;
         q_data      <= 8'h00;
         q_c         <= 2'b00;
      end else begin
         d_prev_q <= d;
         sym_q    <= win[{1'b0, slip_offset} +: 10];

         unique case (state_q)
            StSearch: begin
               if (lock_hit) begin
                  // The token completing the run is itself emitted as valid.
                  state_q <= StLocked;
                  run_q   <= run_q + RunW'(1);
                  idle_q  <= '0;
                  locked  <= 1'b1;
                  q_valid <= 1'b1;
                  q_de    <= 1'b0;
                  q_data  <= 8'h00;
                  q_c     <= ctrl_code;
               end else begin
                  q_valid <= 1'b0;
                  q_de    <= 1'b0;
                  q_data  <= 8'h00;
                  q_c     <= 2'b00;
                  if (slip_evt) begin
                     slip_offset <= (slip_offset == 4'd9) ? 4'd0 : slip_offset + 4'd1;
                     run_q       <= '0;
                     idle_q      <= '0;
                  end else begin
                     run_q  <= is_ctrl ? run_q + RunW'(1) : '0;
                     idle_q <= idle_q + IdleW'(1);
                  end
               end
            end
            StLocked: begin
               if (drop_evt) begin
                  state_q <= StSearch;
                  run_q   <= '0;
                  idle_q  <= '0;
                  locked  <= 1'b0;
                  q_valid <= 1'b0;
                  q_de    <= 1'b0;
                  q_data  <= 8'h00;
                  q_c     <= 2'b00;
               end else begin
                  idle_q  <= is_ctrl ? '0 : idle_q + IdleW'(1);
                  q_valid <= 1'b1;
                  q_de    <= !is_ctrl;
                  q_data  <= is_ctrl ? 8'h00 : data_dec;
                  q_c     <= is_ctrl ? ctrl_code : 2'b00;
               end
            end
            default: state_q <= StSearch;
         endcase
      end
   end

`ifdef SMOLDVI_TMDS_RX_STATS_EN
   logic de_prev_q;

   // Outputs are already gated, so a rising q_de implies q_valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         de_prev_q  <= 1'b0;
         stat_lines <= 16'd0;
         stat_slips <= 8'd0;
      end else begin
         de_prev_q <= q_de;
         if (q_valid && q_de && !de_prev_q) begin
            stat_lines <= stat_lines + 16'd1;
         end
         if (slip_evt && (stat_slips != 8'hFF)) begin
            stat_slips <= stat_slips + 8'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_tmds_rx_align_decode.sv
// Directed bench for tmds_rx_align_decode: alignment, decode, timeout, reset and relock.
module tb_tmds_rx_align_decode;

   localparam int unsigned LockCount = 8;
   localparam int unsigned Timeout   = 16;

   localparam logic [9:0] TokC0 = 10'h354;
   localparam logic [9:0] TokC3 = 10'h2AB;
   localparam logic [9:0] Sym5A = 10'h136;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] d   = 10'd0;
   logic       q_valid;
   logic       q_de;
   logic [7:0] q_data;
   logic [1:0] q_c;
   logic       locked;
   logic [3:0] slip_offset;
`ifdef SMOLDVI_TMDS_RX_STATS_EN
   logic [15:0] stat_lines;
   logic [7:0]  stat_slips;
`endif

   int n_cmp = 0;
   int n_err = 0;

   logic [9:0] vec_sym  [16];
   logic       vec_de   [16];
   logic [7:0] vec_data [16];
   logic [1:0] vec_c    [16];

   always #5 clk = ~clk;

   tmds_rx_align_decode #(
      .LOCK_COUNT     (LockCount),
      .SEARCH_TIMEOUT (Timeout)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .d           (d),
      .q_valid     (q_valid),
      .q_de        (q_de),
      .q_data      (q_data),
      .q_c         (q_c),
      .locked      (locked),
      .slip_offset (slip_offset)
`ifdef SMOLDVI_TMDS_RX_STATS_EN
      ,
      .stat_lines  (stat_lines),
      .stat_slips  (stat_slips)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Drive one word, then sample 1 time unit after the edge that consumes it.
   task automatic step(input logic [9:0] w);
      d = w;
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"},  32'(q_valid), 0);
      check({tag, "_de"},     32'(q_de), 0);
      check({tag, "_data"},   32'(q_data), 0);
      check({tag, "_c"},      32'(q_c), 0);
      check({tag, "_locked"}, 32'(locked), 0);
      check({tag, "_slip"},   32'(slip_offset), 0);
   endtask

   function automatic logic [9:0] line_sym(input int i);
      if (i < 0) return 10'd0;
      return ((i % 140) < 40) ? TokC3 : Sym5A;
   endfunction

   initial begin
      int  idx;
      int  nvalid;
      bit  found;
      bit  dropped;
      bit  got_lock;
      int  lock_step;
      logic [9:0] sj;
      logic [9:0] sp;

      vec_sym  = '{10'h0AB, 10'h154, 10'h2AB, 10'h354, 10'h100, 10'h3FF, 10'h0AA, 10'h255,
                   10'h155, 10'h3AA, 10'h0FF, 10'h200, 10'h180, 10'h37F, 10'h02A, 10'h2D5};
      vec_de   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                   1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      vec_data = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                   8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h80, 8'h80, 8'h80, 8'h80};
      vec_c    = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                   2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};

      // Reset state.
      rst = 1'b1;
      step(10'h3FF);
      step(10'h3FF);
      check_all_zero("reset");
      rst = 1'b0;

      // Aligned token run at offset 0; the 8th token is classified on the 10th edge.
      for (int i = 0; i < 20; i++) begin
         step(TokC0);
         if (i == 8) check("b_locked_before", 32'(locked), 0);
         if (i == 9) begin
            check("b_locked", 32'(locked), 1);
            check("b_valid", 32'(q_valid), 1);
            check("b_c", 32'(q_c), 0);
            check("b_slip", 32'(slip_offset), 0);
         end
      end
      step(Sym5A);
      found = 1'b0;
      for (int k = 0; k < 6; k++) begin
         step(TokC0);
         if (!found && q_valid && q_de) begin
            found = 1'b1;
            check("b_data", 32'(q_data), 32'h5A);
         end
      end
      check("b_data_seen", 32'(found), 1);
      check("b_still_locked", 32'(locked), 1);

      // Exact decode of all control tokens and data variants.
      idx = 0;
      for (int i = 0; i < 22; i++) begin
         step((i < 16) ? vec_sym[i] : TokC0);
         if (idx < 16 && (idx > 0 || (q_valid && (q_de || q_c != 2'b00)))) begin
            check($sformatf("c_valid_%0d", idx), 32'(q_valid), 1);
            check($sformatf("c_de_%0d", idx), 32'(q_de), 32'(vec_de[idx]));
            check($sformatf("c_data_%0d", idx), 32'(q_data), 32'(vec_data[idx]));
            check($sformatf("c_c_%0d", idx), 32'(q_c), 32'(vec_c[idx]));
            idx++;
         end
      end
      check("c_count", 32'(idx), 16);

      // Timeout: 15 data symbols stay valid, the 16th drops lock; then relock.
      nvalid  = 0;
      dropped = 1'b0;
      for (int i = 0; i < 30; i++) begin
         step((i < 16) ? Sym5A : TokC0);
         if (!dropped) begin
            if (locked) begin
               if (q_valid && q_de) nvalid++;
            end else begin
               dropped = 1'b1;
               check("d_valid_at_drop", 32'(q_valid), 0);
               check("d_valid_count", 32'(nvalid), 15);
               check("d_slip_held", 32'(slip_offset), 0);
            end
         end
      end
      check("d_dropped", 32'(dropped), 1);
      check("d_relocked", 32'(locked), 1);
      check("d_relock_slip", 32'(slip_offset), 0);

      // Reset mid-line while locked.
      for (int i = 0; i < 3; i++) step(Sym5A);
      check("e_mid_line_de", 32'(q_de), 1);
      rst = 1'b1;
      step(Sym5A);
      check_all_zero("e_reset");
      rst = 1'b0;
      for (int i = 0; i < 14; i++) step(TokC0);
      check("e_relocked", 32'(locked), 1);
      check("e_valid", 32'(q_valid), 1);
      check("e_c", 32'(q_c), 0);

      // Stream delayed by 3 bits: slips every 16 words, locks at offset 3.
      rst = 1'b1;
      step(10'd0);
      rst = 1'b0;
      got_lock  = 1'b0;
      lock_step = 0;
      found     = 1'b0;
      for (int j = 0; j < 3000 && !found; j++) begin
         sj = line_sym(j);
         sp = line_sym(j - 1);
         step({sj[6:0], sp[9:7]});
         case (j + 1)
            15: check("f_slip_15", 32'(slip_offset), 0);
            16: check("f_slip_16", 32'(slip_offset), 1);
            31: check("f_slip_31", 32'(slip_offset), 1);
            32: check("f_slip_32", 32'(slip_offset), 2);
            48: check("f_slip_48", 32'(slip_offset), 3);
            56: check("f_slip_56", 32'(slip_offset), 3);
            default: ;
         endcase
         if (!got_lock && locked) begin
            got_lock  = 1'b1;
            lock_step = j + 1;
            check("f_lock_slip", 32'(slip_offset), 3);
            check("f_lock_valid", 32'(q_valid), 1);
            check("f_lock_de", 32'(q_de), 0);
            check("f_lock_c", 32'(q_c), 3);
         end else if (got_lock && q_valid && q_de) begin
            found = 1'b1;
            check("f_data", 32'(q_data), 32'h5A);
         end
      end
      check("f_got_lock", 32'(got_lock), 1);
      check("f_lock_edge", 32'(lock_step), 857);
      check("f_data_seen", 32'(found), 1);

`ifdef SMOLDVI_TMDS_RX_STATS_EN
      rst = 1'b1;
      step(10'd0);
      rst = 1'b0;
      for (int l = 0; l < 3; l++) begin
         for (int i = 0; i < 12; i++) step(TokC0);
         for (int i = 0; i < 5; i++) step(Sym5A);
      end
      for (int i = 0; i < 12; i++) step(TokC0);
      check("g_stat_lines", 32'(stat_lines), 3);
      check("g_stat_slips_zero", 32'(stat_slips), 0);
      for (int i = 0; i < 5000; i++) step(Sym5A);
      check("g_stat_slips_sat", 32'(stat_slips), 255);
      check("g_stat_lines_held", 32'(stat_lines), 3);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
